// File: rtl/collision_pkg.sv
// Shared map geometry, collision codes and map-content helpers for collision_detect.
package collision_pkg;

  localparam int unsigned MAP_W     = 40;
  localparam int unsigned MAP_H     = 30;
  localparam int unsigned MAP_CELLS = MAP_W * MAP_H;
  localparam int unsigned X_W       = 6;
  localparam int unsigned Y_W       = 5;
  localparam int unsigned IDX_W     = 11;
  localparam int unsigned COLL_W    = 4;
  localparam int unsigned CNT_W     = 33;
  localparam int unsigned START_X   = 20;
  localparam int unsigned START_Y   = 20;

  localparam logic [COLL_W-1:0] COLL_NONE   = 4'b0000;
  localparam logic [COLL_W-1:0] COLL_WALL   = 4'b0001;
  localparam logic [COLL_W-1:0] COLL_PILL   = 4'b0010;
  localparam logic [COLL_W-1:0] COLL_GHOST1 = 4'b0100;
  localparam logic [COLL_W-1:0] COLL_GHOST2 = 4'b1000;

  // Off-map coordinates count as wall so wrapped moves are rejected.
  function automatic logic is_wall(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
    logic off_map;
    logic border;
    logic inner;
    off_map = (x >= X_W'(MAP_W)) || (y >= Y_W'(MAP_H));
    border  = (x == X_W'(0)) || (x == X_W'(MAP_W - 1)) ||
              (y == Y_W'(0)) || (y == Y_W'(MAP_H - 1));
    inner   = (y[1:0] == 2'b10) && (y <= Y_W'(26)) &&
              (x >= X_W'(3)) && (x <= X_W'(36)) && ((x % X_W'(6)) != X_W'(0));
    return off_map || border || inner;
  endfunction

  function automatic logic [IDX_W-1:0] cell_idx(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
    return IDX_W'(y) * IDX_W'(MAP_W) + IDX_W'(x);
  endfunction

  function automatic logic init_pill(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
    return !is_wall(x, y) && !((x == X_W'(START_X)) && (y == Y_W'(START_Y)));
  endfunction

  function automatic logic [MAP_CELLS-1:0] init_map();
    logic [MAP_CELLS-1:0] m;
    m = '0;
    for (int unsigned yy = 0; yy < MAP_H; yy++) begin
      for (int unsigned xx = 0; xx < MAP_W; xx++) begin
        m[cell_idx(X_W'(xx), Y_W'(yy))] = init_pill(X_W'(xx), Y_W'(yy));
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/collision_detect_pill_map.sv
// One pill bit per map cell; async restore to the start-of-game pattern on reset.
module pill_map
  import collision_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [X_W-1:0]   rd_x,
  input  logic [Y_W-1:0]   rd_y,
  output logic             rd_pill_c,
  input  logic [X_W-1:0]   clr_x,
  input  logic [Y_W-1:0]   clr_y,
  input  logic             clr_en
);

  localparam logic [MAP_CELLS-1:0] INIT_MAP = init_map();

  logic [MAP_CELLS-1:0] map_q;
  logic [MAP_CELLS-1:0] map_d;
  logic [IDX_W-1:0]     rd_idx;
  logic [IDX_W-1:0]     clr_idx;

  assign rd_idx  = cell_idx(rd_x, rd_y);
  assign clr_idx = cell_idx(clr_x, clr_y);

  // Indices past the last cell can arise from off-map coordinates; read them as empty.
  assign rd_pill_c = (rd_idx < IDX_W'(MAP_CELLS)) ? map_q[rd_idx] : 1'b0;

  always_comb begin
    map_d = map_q;
    if (clr_en && (clr_idx < IDX_W'(MAP_CELLS))) begin
      map_d[clr_idx] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      map_q <= INIT_MAP;
    end else begin
      map_q <= map_d;
    end
  end

endmodule

// File: rtl/collision_detect.sv
// Classifies Pac-Man's candidate cell (wall/ghost/pill/empty) and counts pills eaten.
module collision_detect
  import collision_pkg::*;
(
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic [X_W-1:0]    next_pacman_x,
  input  logic [Y_W-1:0]    next_pacman_y,
  input  logic [X_W-1:0]    next_ghost1_x,
  input  logic [Y_W-1:0]    next_ghost1_y,
  input  logic [X_W-1:0]    next_ghost2_x,
  input  logic [Y_W-1:0]    next_ghost2_y,
  output logic [COLL_W-1:0] collision_type,
  output logic [CNT_W-1:0]  pill_count
);

  logic [COLL_W-1:0] coll_q;
  logic [COLL_W-1:0] coll_d;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  count_d;
  logic              in_range_c;
  logic              wall_c;
  logic              ghost1_c;
  logic              ghost2_c;
  logic              pill_c;
  logic              eat_c;

  assign in_range_c = (next_pacman_x < X_W'(MAP_W)) && (next_pacman_y < Y_W'(MAP_H));
  assign wall_c     = !in_range_c || is_wall(next_pacman_x, next_pacman_y);
  assign ghost1_c   = (next_pacman_x == next_ghost1_x) && (next_pacman_y == next_ghost1_y);
  assign ghost2_c   = (next_pacman_x == next_ghost2_x) && (next_pacman_y == next_ghost2_y);

  pill_map u_pill_map (
    .clk       (CLOCK_50),
    .rst_n     (reset),
    .rd_x      (next_pacman_x),
    .rd_y      (next_pacman_y),
    .rd_pill_c (pill_c),
    .clr_x     (next_pacman_x),
    .clr_y     (next_pacman_y),
    .clr_en    (eat_c)
  );

  // Fixed priority: wall, ghost1, ghost2, pill; only a pill result consumes.
  always_comb begin
    coll_d = COLL_NONE;
    eat_c  = 1'b0;
    if (wall_c) begin
      coll_d = COLL_WALL;
    end else if (ghost1_c) begin
      coll_d = COLL_GHOST1;
    end else if (ghost2_c) begin
      coll_d = COLL_GHOST2;
    end else if (pill_c) begin
      coll_d = COLL_PILL;
      eat_c  = 1'b1;
    end
    count_d = count_q + CNT_W'(eat_c);
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      coll_q  <= COLL_NONE;
      count_q <= '0;
    end else begin
      coll_q  <= coll_d;
      count_q <= count_d;
    end
  end

  assign collision_type = coll_q;
  assign pill_count     = count_q;

endmodule

// File: tb/tb_collision_detect.sv
// Directed self-checking bench for collision_detect.
module tb_collision_detect;

  logic        clk;
  logic        rst_n;
  logic [5:0]  pac_x;
  logic [4:0]  pac_y;
  logic [5:0]  g1_x;
  logic [4:0]  g1_y;
  logic [5:0]  g2_x;
  logic [4:0]  g2_y;
  logic [3:0]  coll;
  logic [32:0] cnt;

  int errors = 0;
  int checks = 0;

  collision_detect dut (
    .CLOCK_50       (clk),
    .reset          (rst_n),
    .next_pacman_x  (pac_x),
    .next_pacman_y  (pac_y),
    .next_ghost1_x  (g1_x),
    .next_ghost1_y  (g1_y),
    .next_ghost2_x  (g2_x),
    .next_ghost2_y  (g2_y),
    .collision_type (coll),
    .pill_count     (cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [5:0] x, input logic [4:0] y);
    pac_x = x;
    pac_y = y;
  endtask

  task automatic ghosts_away();
    g1_x = 6'd62; g1_y = 5'd31;
    g2_x = 6'd61; g2_y = 5'd31;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ghosts_away();
    drive(6'd20, 5'd20);
    #3;
    checks++;
    if (coll !== 4'b0000) begin $display("FAIL reset_coll got=%b exp=%b", coll, 4'b0000); errors++; end
    checks++;
    if (cnt !== 33'd0) begin $display("FAIL reset_cnt got=%0d exp=%0d", cnt, 0); errors++; end
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_pill_eat();
    drive(6'd20, 5'd19);
    step();
    checks++;
    if (coll !== 4'b0010) begin $display("FAIL eat_coll got=%b exp=%b", coll, 4'b0010); errors++; end
    checks++;
    if (cnt !== 33'd1) begin $display("FAIL eat_cnt got=%0d exp=%0d", cnt, 1); errors++; end
    step();
    checks++;
    if (coll !== 4'b0000) begin $display("FAIL eat_gone got=%b exp=%b", coll, 4'b0000); errors++; end
    checks++;
    if (cnt !== 33'd1) begin $display("FAIL eat_once got=%0d exp=%0d", cnt, 1); errors++; end
  endtask

  task automatic test_start_and_wall();
    drive(6'd20, 5'd20);
    step();
    checks++;
    if (coll !== 4'b0000) begin $display("FAIL start_cell got=%b exp=%b", coll, 4'b0000); errors++; end
    checks++;
    if (cnt !== 33'd1) begin $display("FAIL start_cnt got=%0d exp=%0d", cnt, 1); errors++; end
    drive(6'd20, 5'd22);
    step();
    checks++;
    if (coll !== 4'b0001) begin $display("FAIL inner_wall got=%b exp=%b", coll, 4'b0001); errors++; end
    drive(6'd39, 5'd15);
    step();
    checks++;
    if (coll !== 4'b0001) begin $display("FAIL right_border got=%b exp=%b", coll, 4'b0001); errors++; end
  endtask

  task automatic test_range();
    logic [5:0] xs [3];
    logic [4:0] ys [3];
    xs[0] = 6'd0;  ys[0] = 5'd5;
    xs[1] = 6'd63; ys[1] = 5'd5;
    xs[2] = 6'd5;  ys[2] = 5'd31;
    for (int i = 0; i < 3; i++) begin
      drive(xs[i], ys[i]);
      step();
      checks++;
      if (coll !== 4'b0001) begin
        $display("FAIL range_wall(%0d,%0d) got=%b exp=%b", xs[i], ys[i], coll, 4'b0001); errors++;
      end
    end
    drive(6'd18, 5'd22);
    step();
    checks++;
    if (coll !== 4'b0010) begin $display("FAIL gap_pill got=%b exp=%b", coll, 4'b0010); errors++; end
    checks++;
    if (cnt !== 33'd2) begin $display("FAIL gap_cnt got=%0d exp=%0d", cnt, 2); errors++; end
    drive(6'd38, 5'd28);
    step();
    checks++;
    if (coll !== 4'b0010) begin $display("FAIL corner_pill got=%b exp=%b", coll, 4'b0010); errors++; end
    checks++;
    if (cnt !== 33'd3) begin $display("FAIL corner_cnt got=%0d exp=%0d", cnt, 3); errors++; end
  endtask

  task automatic test_ghost();
    drive(6'd20, 5'd21);
    g1_x = 6'd20; g1_y = 5'd21;
    step();
    checks++;
    if (coll !== 4'b0100) begin $display("FAIL ghost1_hit got=%b exp=%b", coll, 4'b0100); errors++; end
    step();
    checks++;
    if (coll !== 4'b0100) begin $display("FAIL ghost1_hold got=%b exp=%b", coll, 4'b0100); errors++; end
    checks++;
    if (cnt !== 33'd3) begin $display("FAIL ghost_no_eat got=%0d exp=%0d", cnt, 3); errors++; end
    ghosts_away();
    step();
    checks++;
    if (coll !== 4'b0010) begin $display("FAIL ghost_left_pill got=%b exp=%b", coll, 4'b0010); errors++; end
    checks++;
    if (cnt !== 33'd4) begin $display("FAIL ghost_left_cnt got=%0d exp=%0d", cnt, 4); errors++; end
  endtask

  task automatic test_priority();
    drive(6'd10, 5'd5);
    g1_x = 6'd10; g1_y = 5'd5;
    g2_x = 6'd10; g2_y = 5'd5;
    step();
    checks++;
    if (coll !== 4'b0100) begin $display("FAIL prio_g1_over_g2 got=%b exp=%b", coll, 4'b0100); errors++; end
    g1_x = 6'd62;
    step();
    checks++;
    if (coll !== 4'b1000) begin $display("FAIL ghost2_hit got=%b exp=%b", coll, 4'b1000); errors++; end
    checks++;
    if (cnt !== 33'd4) begin $display("FAIL ghost2_no_eat got=%0d exp=%0d", cnt, 4); errors++; end
    drive(6'd20, 5'd22);
    g1_x = 6'd20; g1_y = 5'd22;
    g2_x = 6'd20; g2_y = 5'd22;
    step();
    checks++;
    if (coll !== 4'b0001) begin $display("FAIL prio_wall_over_ghost got=%b exp=%b", coll, 4'b0001); errors++; end
    ghosts_away();
  endtask

  task automatic test_mid_reset();
    logic [5:0] xs [3];
    logic [4:0] ys [3];
    xs[0] = 6'd5; ys[0] = 5'd5;
    xs[1] = 6'd5; ys[1] = 5'd7;
    xs[2] = 6'd7; ys[2] = 5'd7;
    for (int i = 0; i < 3; i++) begin
      drive(xs[i], ys[i]);
      step();
      checks++;
      if (cnt !== 33'(5 + i)) begin $display("FAIL burst_cnt%0d got=%0d exp=%0d", i, cnt, 5 + i); errors++; end
    end
    drive(6'd5, 5'd5);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (coll !== 4'b0000) begin $display("FAIL midrst_coll got=%b exp=%b", coll, 4'b0000); errors++; end
    checks++;
    if (cnt !== 33'd0) begin $display("FAIL midrst_cnt got=%0d exp=%0d", cnt, 0); errors++; end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    checks++;
    if (coll !== 4'b0010) begin $display("FAIL restored_pill got=%b exp=%b", coll, 4'b0010); errors++; end
    checks++;
    if (cnt !== 33'd1) begin $display("FAIL restored_cnt got=%0d exp=%0d", cnt, 1); errors++; end
  endtask

  initial begin
    test_reset();
    test_pill_eat();
    test_start_and_wall();
    test_range();
    test_ghost();
    test_priority();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/collision_detect.md
# collision_detect

Classifies the cell Pac-Man is about to enter on the 40x30 tile map as wall, ghost, pill or empty, and tracks how many pills have been eaten. It sits between the movement controllers and the game logic. `pacman_loc_ctrl` feeds it the candidate Pac-Man position and reads `collision_type` back to accept or reject the move. The ghost controllers supply ghost target positions.

## Interface
Parameters: none (map geometry lives in the shared package).

- `CLOCK_50`  in  1  system clock; all state changes on its rising edge
- `reset`  in  1  asynchronous, active-low reset (one clock; reset is asynchronous and active-low)
- `next_pacman_x`  in  6  candidate Pac-Man column
- `next_pacman_y`  in  5  candidate Pac-Man row
- `next_ghost1_x`  in  6  ghost 1 target column
- `next_ghost1_y`  in  5  ghost 1 target row
- `next_ghost2_x`  in  6  ghost 2 target column
- `next_ghost2_y`  in  5  ghost 2 target row
- `collision_type`  out  4  one-hot classification, registered: 0000 none, 0001 wall, 0010 pill, 0100 ghost1, 1000 ghost2
- `pill_count`  out  33  pills eaten since reset, registered

## Operation
- Playfield is 40 columns (x 0..39) by 30 rows (y 0..29).
- A coordinate with x ≥ 40 or y ≥ 30 is treated as a wall. This also covers wrap-around from 0−1 to 63 or 31.
- A cell is a wall when any of these holds:
  - x = 0, x = 39, y = 0 or y = 29 (border).
  - y ∈ {2,6,10,14,18,22,26}, and x in 3..36, and x mod 6 ≠ 0 (interior rows; gaps every 6th column).
- Pill map: one bit per cell.
  - After reset, every non-wall cell holds a pill except the start cell (20,20).
  - Wall cells never hold pills.
- Classification of (next_pacman_x, next_pacman_y) uses fixed priority:
  - wall (0001)
  - then equal to ghost1 position (0100)
  - then equal to ghost2 position (1000)
  - then pill present (0010)
  - else 0000.
- Exactly one bit is set, or none.
- On a pill result, the same clock edge clears that cell's pill bit and increments `pill_count` by 1. The pill is never counted twice.
- A ghost result suppresses pill consumption in that cycle.
- Ghost-vs-wall is not checked. Ghost inputs only matter through equality with the Pac-Man position.

## Timing
- Reset (asserted low, asynchronous): `collision_type` = 0000, `pill_count` = 0, pill map restored to its initial pattern.
- Reset asserted mid-game restores the full map immediately.
- Latency is one cycle: `collision_type` reflects the inputs sampled on the previous rising edge. This matches `pacman_loc_ctrl`, which sets its candidate in `still` and reads the result in `move` one or more cycles later.
- Inputs held constant: `collision_type` stays stable, except that a pill result becomes 0000 on the next cycle because the pill is gone.
- There is no handshake. The block evaluates continuously every cycle.
- `pill_count` does not saturate; 33 bits cannot overflow within 1200 cells.

## Structure
- Package `collision_pkg` holds:
  - `MAP_W` = 40 and `MAP_H` = 30.
  - Localparams for the four collision codes.
  - A pure function `is_wall(x, y)` implementing the wall rules.
  - A function giving the initial pill bit per cell.
- Sub-module `pill_map` holds the 1200-bit pill register with an asynchronous restore on reset. It has:
  - a combinational read port taking (x, y);
  - a single clear port taking (x, y, en).
- Top level handles in-range checking, the priority encoder, the output register and the counter.

## Test plan
- Reset low → `collision_type` = 0000 and `pill_count` = 0. Then release reset and drive Pac-Man (20,19) → next cycle 0010, `pill_count` = 1, following cycle 0000.
- Drive (20,20) (start cell) → 0000 and count unchanged. Drive (20,22) → 0001.
- Drive (0,5), (63,5) and (5,31) → 0001 each. Drive (18,22) (gap column) → 0010.
- Drive Pac-Man (20,21) with ghost1 = (20,21) → 0100 and pill not consumed. Move ghost1 away → 0010 and count increments.
- Drive ghost1 = ghost2 = Pac-Man = (10,5) → 0100 (ghost1 priority). Drive a wall cell with a ghost on it → 0001.
- Eat 3 pills, assert reset mid-cycle → outputs clear immediately. Re-drive the first eaten cell → 0010 again.
